phase_timer: RTL and testbench
==============================

Name: phase_timer

Overview:
- Phase-duration timer at the other end of the traffic controller's counter interface.
- Watches the four light outputs and the load_counter strobe, detects phase entry, and drives counter_value back to the controller.
- Green phases may be stretched by the served direction's sensor level; orange phases use a fixed duration.
- Sole producer of counter_value in the intersection design.

Parameters:
- CW, 5, counter width; must match the controller's counter_value width.
- GREEN_BASE, 8, base green duration in cycles; must be >= 1.
- GREEN_STEP, 4, extra green cycles per sensor level.
- ORANGE_TIME, 3, orange duration in cycles; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- Ta,Tb,Tc,Td  in  3 each  light codes from the controller: 001 green, 010 orange, 100 red.
- Sa,Sb,Sc,Sd  in  2 each  traffic sensor levels, 0-3.
- load_counter  in  1  forced-reload strobe from the controller.
- counter_value  out  CW  remaining phase time; 0 means expired.
- phase_change  out  1  registered one-cycle pulse following each reload.
- fault  out  1  registered flag; set while the light pattern is illegal.

Behaviour:
- Interface contract: one clock (clk); reset (rst) is synchronous and active-high.
- Phase decode (combinational, every cycle):
  - Valid pattern: exactly one direction shows 001 or 010, and the other three show 100.
  - Valid phases: G_A..G_D, O_A..O_D (8 codes).
  - Anything else is INVALID.
- State: cnt_q[CW-1:0], prev_phase (8 phase codes plus INVALID), phase_change_q, fault_q.
- Reset (rst=1 at an edge):
  - cnt_q=0, prev_phase=INVALID, phase_change=0, fault=0.
  - counter_value is forced to 0 while rst=1.
- Trigger: phase valid AND (phase != prev_phase OR load_counter=1).
  - A phase change and load_counter in the same cycle produce one reload, not two.
- Reload value R:
  - Green phase: GREEN_BASE + GREEN_STEP * S_dir, where S_dir is the sensor of the green direction.
  - Orange phase: ORANGE_TIME.
  - Computed in CW+4 bits, then saturated to 2^CW-1.
- counter_value (Mealy, no combinational loop because the lights depend only on controller state):
  - 0 if rst or the phase is INVALID.
  - else R if trigger.
  - else cnt_q.
- Edge update, in priority order:
  - rst: reset values.
  - INVALID phase: cnt_q=0, prev_phase=INVALID.
  - trigger: cnt_q=R-1, prev_phase=phase.
  - otherwise: cnt_q decrements, saturating at 0 (no wrap).
- Timing: the phase-entry cycle shows R, then R-1 ... 0. The counter holds 0 until the next trigger, so the controller is free to hold a green on sensor dominance indefinitely.
- phase_change_q <= trigger & ~rst.
- fault_q <= (phase==INVALID) & ~rst. fault clears the cycle after a valid pattern returns, and that return is itself a trigger because prev_phase=INVALID.
- load_counter during an INVALID phase: ignored.
- Sensor inputs are sampled only in the trigger cycle. Later sensor changes do not alter a running count.
- Reset mid-count: the count is discarded. After release, the first valid cycle reloads for the current phase.

Optional Feature:
- Macro: PHASE_TIMER_SENSOR_SCALE_EN.
- Defined: green R = GREEN_BASE + GREEN_STEP * S_dir, saturated as above.
- Undefined: green R = GREEN_BASE regardless of sensors, the GREEN_STEP arithmetic is not built, and the sensor inputs are unused.
- Orange behaviour is identical either way.

Test Plan:
- Reset and first load: rst=1 for 2 cycles with lights G_A and Sa=0 -> counter_value=0, fault=0, phase_change=0. Release rst -> counter_value=8, 7, ..., 0, then holds 0; phase_change=1 on the cycle after the 8.
- Orange entry: lights G_A -> O_A while counter=0 -> counter_value=3, 2, 1, 0 starting the same cycle; phase_change pulses once.
- Sensor scaling (macro on): G_B entry with Sb=3 -> 20. GREEN_BASE=25, Sb=3 -> 31 (saturated). Macro off, Sb=3 -> 8.
- Illegal pattern: Ta=001, Tb=001 mid-count -> counter_value=0 immediately, fault=1 next cycle. Restore G_C (Sc=0) -> 8 the same cycle, fault=0 next cycle.
- Forced reload: G_D with Sd=1, counter at 5, load_counter=1 for one cycle -> counter_value=12, then 11. load_counter coincident with a phase change -> one reload, one phase_change pulse.
- Reset mid-operation: counter at 7, rst=1 one cycle -> counter_value=0. Release with lights O_B -> 3, 2, 1, 0.

Source files
------------

// File: rtl/phase_timer.sv
// Phase-duration timer: decodes the controller's light pattern, reloads on phase entry or
// forced load, and counts down. Optional macro PHASE_TIMER_SENSOR_SCALE_EN stretches greens by sensor level.
module phase_timer #(
    parameter int CW          = 5,
    parameter int GREEN_BASE  = 8,
    parameter int GREEN_STEP  = 4,
    parameter int ORANGE_TIME = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    Ta,
    input  logic [2:0]    Tb,
    input  logic [2:0]    Tc,
    input  logic [2:0]    Td,
    input  logic [1:0]    Sa,
    input  logic [1:0]    Sb,
    input  logic [1:0]    Sc,
    input  logic [1:0]    Sd,
    input  logic          load_counter,
    output logic [CW-1:0] counter_value,
    output logic          phase_change,
    output logic          fault
);

    typedef enum logic [3:0] {
        PH_INVALID,
        PH_GA, PH_GB, PH_GC, PH_GD,
        PH_OA, PH_OB, PH_OC, PH_OD
    } phase_t;

    localparam logic [2:0] L_GREEN  = 3'b001;
    localparam logic [2:0] L_ORANGE = 3'b010;
    localparam logic [2:0] L_RED    = 3'b100;

    // Reload arithmetic runs four bits wider than the counter so saturation can be detected.
    localparam int          RW    = CW + 4;
    localparam logic [RW-1:0] R_MAX = RW'((1 << CW) - 1);

    phase_t        phase;
    phase_t        prev_phase;
    logic [1:0]    s_dir;
    logic          phase_valid;
    logic          is_green;
    logic          trigger;
    logic [RW-1:0] r_wide;
    logic [CW-1:0] r_sat;
    logic [CW-1:0] cnt_q;
    logic          phase_change_q;
    logic          fault_q;

    // NOTE: every signal gets a default before the branches, so no path can infer a latch.
    always_comb begin
        phase = PH_INVALID;
        s_dir = 2'd0;
        if (Tb == L_RED && Tc == L_RED && Td == L_RED) begin
            if (Ta == L_GREEN) begin
                phase = PH_GA;
                s_dir = Sa;
            end else if (Ta == L_ORANGE) begin
                phase = PH_OA;
            end
        end else if (Ta == L_RED && Tc == L_RED && Td == L_RED) begin
            if (Tb == L_GREEN) begin
                phase = PH_GB;
                s_dir = Sb;
            end else if (Tb == L_ORANGE) begin
                phase = PH_OB;
            end
        end else if (Ta == L_RED && Tb == L_RED && Td == L_RED) begin
            if (Tc == L_GREEN) begin
                phase = PH_GC;
                s_dir = Sc;
            end else if (Tc == L_ORANGE) begin
                phase = PH_OC;
            end
        end else if (Ta == L_RED && Tb == L_RED && Tc == L_RED) begin
            if (Td == L_GREEN) begin
                phase = PH_GD;
                s_dir = Sd;
            end else if (Td == L_ORANGE) begin
                phase = PH_OD;
            end
        end
    end

    assign phase_valid = (phase != PH_INVALID);
    assign is_green    = (phase == PH_GA) || (phase == PH_GB) ||
                         (phase == PH_GC) || (phase == PH_GD);
    assign trigger     = phase_valid && ((phase != prev_phase) || load_counter);

    always_comb begin
        r_wide = RW'(ORANGE_TIME);
        if (is_green) begin
`ifdef PHASE_TIMER_SENSOR_SCALE_EN
            r_wide = RW'(GREEN_BASE) + RW'(GREEN_STEP) * RW'(s_dir);
`else
            r_wide = RW'(GREEN_BASE);
`endif
        end
        r_sat = (r_wide > R_MAX) ? R_MAX[CW-1:0] : r_wide[CW-1:0];
    end

`ifndef PHASE_TIMER_SENSOR_SCALE_EN
    // Fixed greens ignore the sensors; fold them into a sink so the selection has a load.
    logic unused_sensor;
    assign unused_sensor = ^s_dir;
`endif

    // The entry cycle shows R combinationally; the register then continues from R-1.
    always_comb begin
        counter_value = cnt_q;
        if (rst || !phase_valid) begin
            counter_value = '0;
        end else if (trigger) begin
            counter_value = r_sat;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            prev_phase     <= PH_INVALID;
            phase_change_q <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            phase_change_q <= trigger;
            fault_q        <= !phase_valid;
            if (!phase_valid) begin
                cnt_q      <= '0;
                prev_phase <= PH_INVALID;
            end else if (trigger) begin
                cnt_q      <= r_sat - CW'(1);
                prev_phase <= phase;
            end else if (cnt_q != '0) begin
                cnt_q      <= cnt_q - CW'(1);
            end
        end
    end

    assign phase_change = phase_change_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer: a per-cycle vector table plus a saturation sequence
// on a second instance with GREEN_BASE=25.
module tb_phase_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] Ta, Tb, Tc, Td;
    logic [1:0] Sa, Sb, Sc, Sd;
    logic       load_counter;
    logic [4:0] counter_value;
    logic       phase_change;
    logic       fault;
    logic [4:0] sat_counter_value;
    logic       sat_phase_change;
    logic       sat_fault;

    always #5 clk = ~clk;

    phase_timer dut (
        .clk(clk), .rst(rst),
        .Ta(Ta), .Tb(Tb), .Tc(Tc), .Td(Td),
        .Sa(Sa), .Sb(Sb), .Sc(Sc), .Sd(Sd),
        .load_counter(load_counter),
        .counter_value(counter_value),
        .phase_change(phase_change),
        .fault(fault)
    );

    phase_timer #(.GREEN_BASE(25)) dut_sat (
        .clk(clk), .rst(rst),
        .Ta(Ta), .Tb(Tb), .Tc(Tc), .Td(Td),
        .Sa(Sa), .Sb(Sb), .Sc(Sc), .Sd(Sd),
        .load_counter(load_counter),
        .counter_value(sat_counter_value),
        .phase_change(sat_phase_change),
        .fault(sat_fault)
    );

`ifdef PHASE_TIMER_SENSOR_SCALE_EN
    localparam int STEP_EFF = 4;
`else
    localparam int STEP_EFF = 0;
`endif

    // Bench phase codes: 0-3 green A-D, 4-7 orange A-D, 8 two greens, 9 all red.
    localparam int GA = 0, GB = 1, GC = 2, GD = 3;
    localparam int OA = 4, OB = 5, OD = 7;
    localparam int BAD = 8, ALLRED = 9;

    typedef struct {
        int         ph;
        logic [7:0] sens;   // {Sa,Sb,Sc,Sd}
        logic       ld;
        logic       rst;
        int         cnt;
        logic       pc;
        logic       flt;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;

    function automatic int g(input int lvl);
        return 8 + STEP_EFF * lvl;
    endfunction

    function automatic int sat_green(input int lvl);
        int r;
        r = 25 + STEP_EFF * lvl;
        return (r > 31) ? 31 : r;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic drive(input int ph, input logic [7:0] sens, input logic ld, input logic r);
        logic [2:0] l [4];
        for (int i = 0; i < 4; i++) l[i] = 3'b100;
        if (ph < 4)       l[ph]     = 3'b001;
        else if (ph < 8)  l[ph - 4] = 3'b010;
        else if (ph == 8) begin
            l[0] = 3'b001;
            l[1] = 3'b001;
        end
        {Ta, Tb, Tc, Td}  = {l[0], l[1], l[2], l[3]};
        {Sa, Sb, Sc, Sd}  = sens;
        load_counter      = ld;
        rst               = r;
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic step(input int ph, input logic [7:0] sens, input logic ld, input logic r);
        @(posedge clk);
        #1;
        drive(ph, sens, ld, r);
        @(negedge clk);
    endtask

    task automatic add(input int ph, input logic [7:0] sens, input logic ld, input logic r,
                       input int cnt, input logic pc, input logic flt);
        vec_t v;
        v.ph = ph; v.sens = sens; v.ld = ld; v.rst = r;
        v.cnt = cnt; v.pc = pc; v.flt = flt;
        vecs.push_back(v);
    endtask

    initial begin
        drive(GA, 8'h00, 1'b0, 1'b1);

        // Reset, then first green load counting down to a held zero.
        add(GA, 8'h00, 0, 1, 0, 0, 0);
        add(GA, 8'h00, 0, 1, 0, 0, 0);
        add(GA, 8'h00, 0, 0, 8, 0, 0);
        for (int c = 7; c >= 0; c--) add(GA, 8'h00, 0, 0, c, (c == 7), 0);
        add(GA, 8'h00, 0, 0, 0, 0, 0);
        // Orange entry.
        add(OA, 8'h00, 0, 0, 3, 0, 0);
        add(OA, 8'h00, 0, 0, 2, 1, 0);
        add(OA, 8'h00, 0, 0, 1, 0, 0);
        add(OA, 8'h00, 0, 0, 0, 0, 0);
        add(OA, 8'h00, 0, 0, 0, 0, 0);
        // Green B with Sb=3; a later sensor drop must not disturb the count.
        add(GB, 8'h30, 0, 0, g(3),     0, 0);
        add(GB, 8'h30, 0, 0, g(3) - 1, 1, 0);
        add(GB, 8'h00, 0, 0, g(3) - 2, 0, 0);
        // Illegal pattern mid-count, load ignored, then recovery on green C.
        add(BAD, 8'h00, 0, 0, 0, 0, 0);
        add(BAD, 8'h00, 1, 0, 0, 0, 1);
        add(GC,  8'h00, 0, 0, 8, 0, 1);
        add(GC,  8'h00, 0, 0, 7, 1, 0);
        // Green D with Sd=1 (Sa=3 must not matter), then forced reload.
        add(GD, 8'hC1, 0, 0, g(1),     0, 0);
        add(GD, 8'hC1, 0, 0, g(1) - 1, 1, 0);
        add(GD, 8'hC1, 0, 0, g(1) - 2, 0, 0);
        add(GD, 8'hC1, 0, 0, g(1) - 3, 0, 0);
        add(GD, 8'hC1, 1, 0, g(1),     0, 0);
        add(GD, 8'hC1, 0, 0, g(1) - 1, 1, 0);
        add(GD, 8'hC1, 0, 0, g(1) - 2, 0, 0);
        // Load coincident with a phase change: a single reload and pulse.
        add(OD, 8'h00, 1, 0, 3, 0, 0);
        add(OD, 8'h00, 0, 0, 2, 1, 0);
        add(OD, 8'h00, 0, 0, 1, 0, 0);
        // Reset mid-count, release into orange B.
        add(GA, 8'h00, 0, 0, 8, 0, 0);
        add(GA, 8'h00, 0, 0, 7, 1, 0);
        add(GA, 8'h00, 0, 1, 0, 0, 0);
        add(OB, 8'h00, 0, 0, 3, 0, 0);
        add(OB, 8'h00, 0, 0, 2, 1, 0);
        add(OB, 8'h00, 0, 0, 1, 0, 0);
        add(OB, 8'h00, 0, 0, 0, 0, 0);
        add(OB, 8'h00, 0, 0, 0, 0, 0);
        // All red is also illegal.
        add(ALLRED, 8'h00, 0, 0, 0, 0, 0);
        add(ALLRED, 8'h00, 0, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            step(vecs[i].ph, vecs[i].sens, vecs[i].ld, vecs[i].rst);
            check($sformatf("row%0d.counter_value", i), int'(counter_value), vecs[i].cnt);
            check($sformatf("row%0d.phase_change", i), int'(phase_change), int'(vecs[i].pc));
            check($sformatf("row%0d.fault", i), int'(fault), int'(vecs[i].flt));
        end

        // Saturation: GREEN_BASE=25 with Sb=3 clips at 31 when scaling is built.
        step(GB, 8'h30, 1'b0, 1'b0);
        check("sat.entry_main", int'(counter_value), g(3));
        check("sat.entry_value", int'(sat_counter_value), sat_green(3));
        check("sat.entry_fault", int'(sat_fault), 1);
        step(GB, 8'h30, 1'b0, 1'b0);
        check("sat.next_value", int'(sat_counter_value), sat_green(3) - 1);
        check("sat.next_pulse", int'(sat_phase_change), 1);
        check("sat.next_fault", int'(sat_fault), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
